seg_display_driver: RTL

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_pkg.sv | 52 +++++
 rtl/seg7_encode.sv | 37 +++
 rtl/seg_display_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display driver: controller state
// encoding, sizing constants, active-high gfedcba segment codes, the "Err"
// pattern and the double-dabble nibble adjust helper.
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

   localparam int DIGITS      = 5;
   localparam int MAX_DISPLAY = 99999;
   localparam int ITER        = 17;
   localparam int VALUE_W     = 17;
   localparam int BCD_W       = 4 * DIGITS;
   localparam int SEG_W       = 7;
   localparam int CNT_W       = 5;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
   localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_R     = 7'h50;

   // digit4..digit0 = "E r r _ _"
   localparam logic [DIGITS*SEG_W-1:0] ERR_PATTERN =
      {SEG_E, SEG_R, SEG_R, SEG_BLANK, SEG_BLANK};

   // Double-dabble correction step: any nibble >= 5 gets +3 so that the
   // following left shift carries correctly into the next decimal digit.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] r;
      r = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
// Combinational BCD digit to active-high gfedcba segment decoder.
// Ports:
//   bcd   in  4  BCD digit (10..15 decode to blank)
//   blank in  1  force the digit dark
//   seg   out 7  segment code, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module seg7_encode
   import seg_pkg::*;
(
   input  logic [3:0]       bcd,
   input  logic             blank,
   output logic [SEG_W-1:0] seg
);

   // NOTE: assign a default before the case so every path drives seg and no latch is inferred.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg_display_driver.sv
// -----------------------------------------------------------------------------
// seg_display_driver
// Converts a 17-bit binary total to five seven-segment digits using a
// sequential double-dabble (17 adjust-and-shift iterations), with optional
// leading-zero suppression and an "Err" pattern for errors or values > 99999.
// Ports:
//   clk      in  1   rising-edge clock
//   reset    in  1   asynchronous, active-high reset
//   load     in  1   strobe: convert value/err_in (accepted only when ready)
//   value    in  17  unsigned binary total
//   err_in   in  1   error flag from the execution stage
//   ready    out 1   idle and able to accept load
//   valid    out 1   one-cycle pulse after seg_out is updated
//   seg_out  out 35  digit4 [34:28] ... digit0 [6:0]
//   overflow out 1   displayed pattern is the error pattern
// Parameter:
//   BLANK_LZ 1 = blank leading zeros, 0 = show all five digits
// -----------------------------------------------------------------------------
module seg_display_driver
   import seg_pkg::*;
#(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [VALUE_W-1:0]      value,
   input  logic                    err_in,
   output logic                    ready,
   output logic                    valid,
   output logic [DIGITS*SEG_W-1:0] seg_out,
   output logic                    overflow
);

   state_t                    state;
   state_t                    state_next;
   logic [CNT_W-1:0]          cnt;
   logic [BCD_W-1:0]          bcd;
   logic [BCD_W-1:0]          bcd_adj;
   logic [VALUE_W-1:0]        bin;
   logic                      err_q;
   logic                      range_q;
   logic [DIGITS-1:0]         blank;
   logic                      lead;
   logic [DIGITS*SEG_W-1:0]   seg_enc;

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = CONVERT;
         CONVERT: if (cnt == CNT_W'(1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign ready = (state == IDLE);

   // ----------------------------------------------------------- datapath
   assign bcd_adj = bcd_adjust(bcd);

   // NOTE: every register here, including the display register, is reset so an abort leaves a known blank display.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         bcd      <= '0;
         bin      <= '0;
         err_q    <= 1'b0;
         range_q  <= 1'b0;
         seg_out  <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  bin     <= value;
                  err_q   <= err_in;
                  range_q <= (value > VALUE_W'(MAX_DISPLAY));
                  bcd     <= '0;
                  cnt     <= CNT_W'(ITER);
               end
            end
            CONVERT: begin
               // Bits shifted out past bcd[19] are dropped; out-of-range
               // values are shown as "Err" regardless.
               {bcd, bin} <= {bcd_adj, bin} << 1;
               cnt        <= cnt - CNT_W'(1);
            end
            DONE: begin
               seg_out  <= (err_q || range_q) ? ERR_PATTERN : seg_enc;
               overflow <= err_q || range_q;
               valid    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Leading-zero blanking: walk down from digit4 while digits are zero.
   // digit0 is never blanked so a zero total still shows "0".
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (BLANK_LZ && lead && (bcd[i*4 +: 4] == 4'd0)) blank[i] = 1'b1;
         else                                              lead     = 1'b0;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_enc
      seg7_encode u_enc (
         .bcd   (bcd[g*4 +: 4]),
         .blank (blank[g]),
         .seg   (seg_enc[g*SEG_W +: SEG_W])
      );
   end

endmodule
